// File: rtl/apb_reg_bank.sv
// APB3 completer holding the system register file plus the I2C side-channel CTRL nibble.
// Optional macro APB_REG_WAIT_EN inserts WAIT_CYCLES access-phase wait states.
module apb_reg_bank #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 32,
  parameter int unsigned NUM_REGS          = 16,
  parameter logic [DATA_BUS_WIDTH-1:0] ID_VALUE = 32'hEA12_0001,
  parameter int unsigned WAIT_CYCLES       = 2
) (
  input  logic                         clk_sys,
  input  logic                         rst_n,
  input  logic [ADDRESS_BUS_WIDTH-1:0] paddr,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_BUS_WIDTH-1:0]    pwdata,
  output logic [DATA_BUS_WIDTH-1:0]    prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic                         we_i2c,
  input  logic [3:0]                   wdata_i2c,
  output logic [DATA_BUS_WIDTH-1:0]    ctrl_o,
  output logic                         wr_pulse_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (NUM_REGS < 4 || NUM_REGS > 256 || WAIT_CYCLES > 65535) begin : g_bad_param
    $error("apb_reg_bank: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e                        state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [DATA_BUS_WIDTH-1:0]     regs_d [NUM_REGS];
  logic [15:0]                   err_cnt_q, err_cnt_d;
  logic [DATA_BUS_WIDTH-1:0]     prdata_q, prdata_d;
  logic                          pready_q, pready_d;
  logic                          pslverr_q, pslverr_d;
  logic                          wr_pulse_q, wr_pulse_d;

  logic                          setup;
  logic                          complete;
  logic [ADDRESS_BUS_WIDTH-1:0]  t_addr;
  logic                          t_write;
  logic [DATA_BUS_WIDTH-1:0]     t_wdata;
  logic [IDX_W-1:0]              idx;
  logic                          in_range, is_id, is_errcnt, txn_err;
  logic [DATA_BUS_WIDTH-1:0]     rd_val;

  assign setup = psel && !penable;

`ifdef APB_REG_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
  logic                         write_q, write_d;
  logic [DATA_BUS_WIDTH-1:0]    wdata_q, wdata_d;

  // During waits the transfer is served from the copy latched at setup.
  assign t_addr  = (state_q == S_ACCESS) ? addr_q  : paddr;
  assign t_write = (state_q == S_ACCESS) ? write_q : pwrite;
  assign t_wdata = (state_q == S_ACCESS) ? wdata_q : pwdata;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end
`else
  assign t_addr  = paddr;
  assign t_write = pwrite;
  assign t_wdata = pwdata;
`endif

  // Next state; 'complete' marks the edge that commits and raises pready.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
`ifdef APB_REG_WAIT_EN
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (setup) begin
`ifdef APB_REG_WAIT_EN
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_ACCESS;
          end
`else
          complete = 1'b1;
          state_d  = S_DONE;
`endif
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
`ifdef APB_REG_WAIT_EN
        if (psel) begin
          if (cnt_q <= CNT_W'(1)) begin
            complete = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = S_ACCESS;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address decode and read mux for the transfer being completed.
  always_comb begin
    idx       = t_addr[IDX_W-1:0];
    in_range  = t_addr < ADDRESS_BUS_WIDTH'(NUM_REGS);
    is_id     = t_addr == '0;
    is_errcnt = t_addr == ADDRESS_BUS_WIDTH'(3);
    txn_err   = !in_range || (t_write && is_id);
    if (is_id)          rd_val = ID_VALUE;
    else if (is_errcnt) rd_val = DATA_BUS_WIDTH'(err_cnt_q);
    else if (in_range)  rd_val = regs_q[idx];
    else                rd_val = '0;
  end

  always_comb begin
    pready_d   = complete;
    pslverr_d  = complete && txn_err;
    wr_pulse_d = complete && t_write && !txn_err;
    prdata_d   = (complete && !t_write && !txn_err) ? rd_val : '0;

    // Side-channel nibble first so a same-edge APB write to CTRL overrides it.
    regs_d = regs_q;
    if (we_i2c) regs_d[1][3:0] = wdata_i2c;
    if (wr_pulse_d && !is_id && !is_errcnt) regs_d[idx] = t_wdata;

    err_cnt_d = err_cnt_q;
    if (pslverr_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    if (wr_pulse_d && is_errcnt)            err_cnt_d = '0;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_cnt_q  <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign wr_pulse_o = wr_pulse_q;
  assign ctrl_o     = regs_q[1];

endmodule

// File: tb/tb_apb_reg_bank.sv
// Scoreboard bench for apb_reg_bank: stimulus queues expected responses, a monitor checks each pready.
module tb_apb_reg_bank;

`ifdef APB_REG_WAIT_EN
  localparam int TB_WAIT = 2;
`else
  localparam int TB_WAIT = 0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata, ctrl_o;
  logic        pready, pslverr, we_i2c, wr_pulse_o;
  logic [3:0]  wdata_i2c;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
    logic        pulse;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  apb_reg_bank dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .we_i2c(we_i2c), .wdata_i2c(wdata_i2c), .ctrl_o(ctrl_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every pready must match the oldest queued expectation.
  logic prev_pready = 1'b0;
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      prev_pready = 1'b0;
    end else begin
      if (prev_pready) check("pready_one_cycle", {31'd0, pready}, 32'd0);
      if (pready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pready: got pready=1 expected no transfer");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pslverr", {31'd0, pslverr}, {31'd0, e.err});
          check("wr_pulse", {31'd0, wr_pulse_o}, {31'd0, e.pulse});
          if (e.chk_rd) check("prdata", prdata, e.rd);
        end
      end else if (wr_pulse_o) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_wr_pulse: got wr_pulse_o=1 expected 0 without pready");
      end
      prev_pready = pready;
    end
  end

  // Called at posedge+1; returns at posedge+1 with the bus idle, allowing back-to-back calls.
  task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input logic err, output int acc);
    exp_t e;
    logic got;
    e.chk_rd = !wr;
    e.rd     = rd;
    e.err    = err;
    e.pulse  = wr && !err;
    exp_q.push_back(e);
    acc = 0;
    got = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk_sys); #1;
    penable = 1'b1;
    while (!got && acc < 20) begin
      @(negedge clk_sys);
      acc++;
      got = pready;
      if (!got) begin
        @(posedge clk_sys); #1;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL pready_timeout: got no pready after %0d cycles expected one", acc);
    end
    @(posedge clk_sys); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic err);
    int n;
    apb_xfer(1'b1, a, d, 32'd0, err, n);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp_d, input logic err);
    int n;
    apb_xfer(1'b0, a, 32'd0, exp_d, err, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; we_i2c = 1'b0; wdata_i2c = '0;
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;

    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_wr_pulse", {31'd0, wr_pulse_o}, 32'd0);
    check("rst_ctrl", ctrl_o, 32'd0);
    @(posedge clk_sys); #1;

    // ID read and access latency
    apb_xfer(1'b0, 16'd0, 32'd0, 32'hEA12_0001, 1'b0, n);
    check("access_cycles", 32'(n), 32'(TB_WAIT + 1));

    // SCRATCH round trip, back-to-back
    wr(16'd2, 32'hDEAD_BEEF, 1'b0);
    rd(16'd2, 32'hDEAD_BEEF, 1'b0);
    rd(16'd3, 32'd0, 1'b0);

    // Error paths and ERR_CNT
    wr(16'd0, 32'h1111_1111, 1'b1);
    rd(16'd16, 32'd0, 1'b1);
    rd(16'd0, 32'hEA12_0001, 1'b0);
    rd(16'd3, 32'd2, 1'b0);
    wr(16'd3, 32'hFFFF_FFFF, 1'b0);
    rd(16'd3, 32'd0, 1'b0);
    rd(16'hFFFF, 32'd0, 1'b1);
    rd(16'd3, 32'd1, 1'b0);

    // CTRL via APB then side channel
    wr(16'd1, 32'h1234_5670, 1'b0);
    check("ctrl_apb", ctrl_o, 32'h1234_5670);
    we_i2c = 1'b1; wdata_i2c = 4'hA;
    @(posedge clk_sys); #1;
    we_i2c = 1'b0;
    check("ctrl_i2c", ctrl_o, 32'h1234_567A);
    rd(16'd1, 32'h1234_567A, 1'b0);

    // APB write and side channel on the same commit edge
    fork
      wr(16'd1, 32'h0000_00F0, 1'b0);
      begin
        repeat (TB_WAIT) @(posedge clk_sys);
        #1 we_i2c = 1'b1; wdata_i2c = 4'h5;
        @(posedge clk_sys); #1 we_i2c = 1'b0;
      end
    join
    check("ctrl_collision", ctrl_o, 32'h0000_00F0);

    // General registers at both ends of the range
    wr(16'd15, 32'hA5A5_0F0F, 1'b0);
    wr(16'd4, 32'h0000_C0DE, 1'b0);
    rd(16'd4, 32'h0000_C0DE, 1'b0);
    rd(16'd15, 32'hA5A5_0F0F, 1'b0);

    // penable without a setup phase is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'd2; pwdata = 32'h0BAD_0BAD;
    repeat (3) @(posedge clk_sys);
    #1 check("no_setup_pready", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk_sys); #1;
    rd(16'd2, 32'hDEAD_BEEF, 1'b0);

`ifdef APB_REG_WAIT_EN
    // Abort in the second access cycle
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd6; pwdata = 32'h6666_6666;
    @(posedge clk_sys); #1 penable = 1'b1;
    @(posedge clk_sys); #1 psel = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1 check("abort_pready", {31'd0, pready}, 32'd0);
    rd(16'd6, 32'd0, 1'b0);
    rd(16'd3, 32'd1, 1'b0);
`endif

    // Reset in the middle of a write to reg 5
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd5; pwdata = 32'h5555_5555;
    @(posedge clk_sys); #1 penable = 1'b1;
    rst_n = 1'b0;
    #1 check("rst_mid_pready", {31'd0, pready}, 32'd0);
    check("rst_mid_ctrl", ctrl_o, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk_sys); #1 rst_n = 1'b1;
    @(posedge clk_sys); #1;
    rd(16'd5, 32'd0, 1'b0);
    rd(16'd2, 32'd0, 1'b0);
    rd(16'd3, 32'd0, 1'b0);

    repeat (3) @(posedge clk_sys);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
